// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter),
// default oversampling ratio and data width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_W             = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input. The reset value
// is a parameter so idle-high lines (UART rx) come out of reset inactive.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      q_reg    <= RESET_VAL;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver driven by an oversampling tick. Detects the start edge,
// re-checks it at mid start bit, samples each data bit at its centre and the
// stop bit likewise, then hands the byte over with a rdy/rdy_clr handshake.
// Framing errors and overruns are flagged.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_enb,
  input  logic              rx,
  input  logic              rdy_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rdy,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic rx_s;

  uart_state_t       state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [2:0]        idx_reg, idx_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              rdy_reg, rdy_next;
  logic              frame_err_reg, frame_err_next;
  logic              overrun_reg, overrun_next;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // State, counters, shift register and output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      rdy_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      rdy_reg       <= rdy_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Next-state logic; everything except the handshake clear moves only on rx_enb.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    rdy_next       = rdy_reg;
    frame_err_next = frame_err_reg;
    overrun_next   = overrun_reg;

    // Consumer acknowledge; a same-cycle frame completion below overrides it.
    if (rdy_clr) begin
      rdy_next       = 1'b0;
      overrun_next   = 1'b0;
      frame_err_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (rx_enb && !rx_s) begin
          cnt_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (rx_enb) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == HALF_M1) begin
            if (!rx_s) begin
              cnt_next   = '0;
              idx_next   = '0;
              state_next = DATA;
            end else begin
              // Line went high again before mid start bit: a glitch.
              state_next = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (rx_enb) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == FULL_M1) begin
            shift_next[idx_reg] = rx_s;
            cnt_next            = '0;
            if (idx_reg == 3'd7) begin
              state_next = STOP;
            end else begin
              idx_next = idx_reg + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (rx_enb) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == FULL_M1) begin
            cnt_next   = '0;
            state_next = IDLE;
            if (rx_s) begin
              data_next      = shift_reg;
              rdy_next       = 1'b1;
              frame_err_next = 1'b0;
              overrun_next   = rdy_clr ? 1'b0 : (overrun_reg | rdy_reg);
            end else begin
              frame_err_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  assign data_out  = data_reg;
  assign rdy       = rdy_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: OVERSAMPLE=16, rx_enb every 4 clk, so one
// bit lasts 64 clk. Frames are launched two cycles after an rx_enb cycle, which
// puts the stop-bit sample exactly on the clock edge ending cycle 610 of the frame.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_enb = 1'b0;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data_out;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic [1:0] div = 2'd0;
  logic       busy_mid = 1'b0;
  int         checks = 0;
  int         failures = 0;

  uart_receiver #(
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_enb   (rx_enb),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data_out (data_out),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // One-cycle oversampling tick every 4 clocks.
  always @(posedge clk) begin
    div    <= div + 2'd1;
    rx_enb <= (div == 2'd3);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(posedge clk);
    #1;
    rdy_clr = 1'b0;
  endtask

  // Drives one full 10-bit frame (640 clk). clr_at / rst_at pulse rdy_clr / rst
  // for the cycle with that index (-1 disables).
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int clr_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    do begin
      @(posedge clk);
      #1;
    end while (rx_enb !== 1'b1);
    idle(2);
    for (int e = 0; e < 640; e++) begin
      rx      = bits[e / 64];
      rdy_clr = (e == clr_at);
      rst     = (e == rst_at);
      if (e == 300) busy_mid = busy;
      @(posedge clk);
      #1;
    end
    rx      = 1'b1;
    rdy_clr = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(5);
    rst = 1'b0;
    idle(2);
    chk("reset_data", data_out, 8'h00);
    chk("reset_rdy", {7'd0, rdy}, 8'h00);
    chk("reset_ferr", {7'd0, frame_err}, 8'h00);
    chk("reset_ovr", {7'd0, overrun}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, -1, -1);
    chk("a5_busy_mid", {7'd0, busy_mid}, 8'h01);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_rdy", {7'd0, rdy}, 8'h01);
    chk("a5_ferr", {7'd0, frame_err}, 8'h00);
    chk("a5_ovr", {7'd0, overrun}, 8'h00);
    chk("a5_busy_end", {7'd0, busy}, 8'h00);
    pulse_clr();
    chk("a5_clr_rdy", {7'd0, rdy}, 8'h00);

    // Start glitch: 4 ticks low, then high
    rx = 1'b0;
    idle(16);
    chk("glitch_busy_start", {7'd0, busy}, 8'h01);
    rx = 1'b1;
    idle(200);
    chk("glitch_busy_end", {7'd0, busy}, 8'h00);
    chk("glitch_rdy", {7'd0, rdy}, 8'h00);
    chk("glitch_data", data_out, 8'hA5);

    // Framing error: 0x3C with stop=0
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(128);
    chk("ferr_flag", {7'd0, frame_err}, 8'h01);
    chk("ferr_rdy", {7'd0, rdy}, 8'h00);
    chk("ferr_data", data_out, 8'hA5);
    chk("ferr_busy", {7'd0, busy}, 8'h00);
    pulse_clr();
    chk("ferr_clr", {7'd0, frame_err}, 8'h00);

    // Overrun: 0x11 then 0x22 without acknowledge
    send_frame(8'h11, 1'b1, -1, -1);
    chk("ovr_first_data", data_out, 8'h11);
    chk("ovr_first_rdy", {7'd0, rdy}, 8'h01);
    chk("ovr_first_ovr", {7'd0, overrun}, 8'h00);
    send_frame(8'h22, 1'b1, -1, -1);
    chk("ovr_second_data", data_out, 8'h22);
    chk("ovr_second_rdy", {7'd0, rdy}, 8'h01);
    chk("ovr_second_ovr", {7'd0, overrun}, 8'h01);
    pulse_clr();
    chk("ovr_clr_rdy", {7'd0, rdy}, 8'h00);
    chk("ovr_clr_ovr", {7'd0, overrun}, 8'h00);

    // Reset during data bit 4 of 0xFF, then frame 0x5A
    send_frame(8'hFF, 1'b1, -1, 340);
    idle(4);
    chk("rst_mid_data", data_out, 8'h00);
    chk("rst_mid_rdy", {7'd0, rdy}, 8'h00);
    chk("rst_mid_ferr", {7'd0, frame_err}, 8'h00);
    chk("rst_mid_ovr", {7'd0, overrun}, 8'h00);
    chk("rst_mid_busy", {7'd0, busy}, 8'h00);
    send_frame(8'h5A, 1'b1, -1, -1);
    chk("post_rst_data", data_out, 8'h5A);
    chk("post_rst_rdy", {7'd0, rdy}, 8'h01);
    chk("post_rst_ferr", {7'd0, frame_err}, 8'h00);
    chk("post_rst_ovr", {7'd0, overrun}, 8'h00);

    // rdy_clr on the stop-sample cycle of 0x81 while rdy is still set
    send_frame(8'h81, 1'b1, 610, -1);
    chk("race_rdy", {7'd0, rdy}, 8'h01);
    chk("race_data", data_out, 8'h81);
    chk("race_ovr", {7'd0, overrun}, 8'h00);
    chk("race_ferr", {7'd0, frame_err}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
